// File: rtl/door_lock_supervisor.sv
// door_lock_supervisor: conditions three raw pushbuttons into single-cycle key
// strobes for the lock core, counts presses per attempt, collects the core's
// verdict, and sequences the unlock hold window and the repeated-failure lockout.
module door_lock_supervisor #(
    parameter int CODE_LEN       = 5,
    parameter int KEY_TIMEOUT    = 50000000,
    parameter int RESULT_TIMEOUT = 4,
    parameter int MAX_FAILS      = 3,
    parameter int UNLOCK_CYCLES  = 150000000,
    parameter int LOCKOUT_CYCLES = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn,
    output logic       key_valid,
    output logic [1:0] key_code,
    output logic       core_clear,
    input  logic       core_pass,
    input  logic       core_fail,
    output logic       unlocked,
    output logic       locked_out,
    output logic [1:0] fail_count,
    output logic [2:0] press_count
);

    // The one shared timer must cover the longest interval any state measures.
    localparam int MAX_KR = (KEY_TIMEOUT > RESULT_TIMEOUT) ? KEY_TIMEOUT : RESULT_TIMEOUT;
    localparam int MAX_UL = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int MAX_T  = (MAX_KR > MAX_UL) ? MAX_KR : MAX_UL;
    localparam int TW     = $clog2(MAX_T + 1);

    // Terminal counts: the timer starts at 0 on state entry, so an interval of
    // N cycles ends in the cycle where the timer holds N-1.
    localparam logic [TW-1:0] KEY_LAST    = TW'(KEY_TIMEOUT - 1);
    localparam logic [TW-1:0] RESULT_LAST = TW'(RESULT_TIMEOUT - 1);
    localparam logic [TW-1:0] UNLOCK_LAST = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]    CODE_LEN_W  = 3'(CODE_LEN);
    localparam logic [1:0]    MAX_FAILS_W = 2'(MAX_FAILS);

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        VERDICT,
        UNLOCK,
        LOCKOUT
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;

    logic [2:0] sync_meta, sync_stable, sync_hist;
    logic [2:0] rise;
    logic       press_ok;
    logic [1:0] press_idx;
    logic [2:0] press_inc;
    logic [1:0] fail_inc;

    logic       key_valid_next;
    logic [1:0] key_code_next;
    logic       core_clear_next;
    logic       unlocked_next;
    logic       locked_out_next;
    logic [1:0] fail_count_next;
    logic [2:0] press_count_next;

    // Two-flop synchronizer plus a history flop for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta   <= '0;
            sync_stable <= '0;
            sync_hist   <= '0;
        end else begin
            sync_meta   <= btn;
            sync_stable <= sync_meta;
            sync_hist   <= sync_stable;
        end
    end

    // A press counts only when exactly one button rose and no other is held.
    always_comb begin
        rise      = sync_stable & ~sync_hist;
        press_ok  = (rise != 3'b000) && ((rise & (rise - 3'd1)) == 3'b000)
                    && ((sync_stable & ~rise) == 3'b000);
        press_idx = rise[0] ? 2'd0 : (rise[1] ? 2'd1 : 2'd2);
        press_inc = press_count + 3'd1;
        fail_inc  = fail_count + 2'd1;
    end

    // Next-state and next-output decode for the attempt sequencer.
    always_comb begin
        // NOTE: every target gets a default here so no path leaves one unassigned (no latches).
        state_next       = state;
        timer_next       = timer + TW'(1);
        key_valid_next   = 1'b0;
        key_code_next    = 2'd0;
        core_clear_next  = 1'b0;
        unlocked_next    = unlocked;
        locked_out_next  = locked_out;
        fail_count_next  = fail_count;
        press_count_next = press_count;

        case (state)
            IDLE: begin
                timer_next = '0;
                if (press_ok) begin
                    key_valid_next   = 1'b1;
                    key_code_next    = press_idx;
                    press_count_next = 3'd1;
                    state_next       = (CODE_LEN_W == 3'd1) ? VERDICT : ENTRY;
                end
            end
            ENTRY: begin
                if (press_ok) begin
                    key_valid_next   = 1'b1;
                    key_code_next    = press_idx;
                    press_count_next = press_inc;
                    timer_next       = '0;
                    if (press_inc == CODE_LEN_W) begin
                        state_next = VERDICT;
                    end
                end else if (timer == KEY_LAST) begin
                    // Abandoned attempt: flush the core but do not count a failure.
                    core_clear_next  = 1'b1;
                    press_count_next = 3'd0;
                    state_next       = IDLE;
                end
            end
            VERDICT: begin
                if (core_pass && !core_fail) begin
                    unlocked_next    = 1'b1;
                    fail_count_next  = 2'd0;
                    press_count_next = 3'd0;
                    state_next       = UNLOCK;
                end else if (core_fail || timer == RESULT_LAST) begin
                    // A silent core is cleared and charged as a failure; a
                    // contradictory pass+fail is charged as a failure too.
                    core_clear_next  = !core_pass && !core_fail;
                    press_count_next = 3'd0;
                    fail_count_next  = fail_inc;
                    if (fail_inc == MAX_FAILS_W) begin
                        locked_out_next = 1'b1;
                        state_next      = LOCKOUT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            UNLOCK: begin
                if (timer == UNLOCK_LAST) begin
                    unlocked_next = 1'b0;
                    state_next    = IDLE;
                end
            end
            LOCKOUT: begin
                if (timer == LOCK_LAST) begin
                    locked_out_next = 1'b0;
                    fail_count_next = 2'd0;
                    core_clear_next = 1'b1;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Every state entry restarts the shared timer.
        if (state_next != state) begin
            timer_next = '0;
        end
    end

    // State, timer and all outputs are registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            key_valid   <= 1'b0;
            key_code    <= 2'd0;
            core_clear  <= 1'b0;
            unlocked    <= 1'b0;
            locked_out  <= 1'b0;
            fail_count  <= 2'd0;
            press_count <= 3'd0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state       <= state_next;
            timer       <= timer_next;
            key_valid   <= key_valid_next;
            key_code    <= key_code_next;
            core_clear  <= core_clear_next;
            unlocked    <= unlocked_next;
            locked_out  <= locked_out_next;
            fail_count  <= fail_count_next;
            press_count <= press_count_next;
        end
    end

endmodule

// File: tb/tb_door_lock_supervisor.sv
// Directed walk through the door-lock supervisor with randomized button choices
// and gaps, checked against a small attempt-level model kept in the bench.
module tb_door_lock_supervisor;

    localparam int CODE_LEN       = 5;
    localparam int KEY_TIMEOUT    = 16;
    localparam int RESULT_TIMEOUT = 4;
    localparam int MAX_FAILS      = 3;
    localparam int UNLOCK_CYCLES  = 20;
    localparam int LOCKOUT_CYCLES = 30;

    logic       clk;
    logic       reset;
    logic [2:0] btn;
    logic       key_valid;
    logic [1:0] key_code;
    logic       core_clear;
    logic       core_pass;
    logic       core_fail;
    logic       unlocked;
    logic       locked_out;
    logic [1:0] fail_count;
    logic [2:0] press_count;

    door_lock_supervisor #(
        .CODE_LEN      (CODE_LEN),
        .KEY_TIMEOUT   (KEY_TIMEOUT),
        .RESULT_TIMEOUT(RESULT_TIMEOUT),
        .MAX_FAILS     (MAX_FAILS),
        .UNLOCK_CYCLES (UNLOCK_CYCLES),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .core_clear (core_clear),
        .core_pass  (core_pass),
        .core_fail  (core_fail),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .fail_count (fail_count),
        .press_count(press_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Attempt-level model: accepted presses, consecutive failures, keypad open.
    int m_presses = 0;
    int m_fails   = 0;
    bit m_open    = 1'b1;

    // Event log filled by the monitor, 1 ns after each rising edge.
    int cyc       = 0;
    int kv_count  = 0;
    int kv_cyc    = 0;
    int clr_count = 0;
    int clr_cyc   = 0;
    int unl_rise  = 0;
    int unl_len   = 0;
    int lo_rise   = 0;
    int lo_len    = 0;
    int lo_fall   = 0;
    bit unl_q     = 1'b0;
    bit lo_q      = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (key_valid === 1'b1) begin
                kv_count++;
                kv_cyc = cyc;
            end
            if (core_clear === 1'b1) begin
                clr_count++;
                clr_cyc = cyc;
            end
            if (unlocked === 1'b1 && !unl_q) unl_rise = cyc;
            if (unlocked !== 1'b1 && unl_q) unl_len = cyc - unl_rise;
            if (locked_out === 1'b1 && !lo_q) lo_rise = cyc;
            if (locked_out !== 1'b1 && lo_q) begin
                lo_len  = cyc - lo_rise;
                lo_fall = cyc;
            end
            unl_q = (unlocked === 1'b1);
            lo_q  = (locked_out === 1'b1);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_unlocked"}, unlocked, 0);
        check({tag, "_locked_out"}, locked_out, 0);
        check({tag, "_fail_count"}, fail_count, 0);
        check({tag, "_press_count"}, press_count, 0);
        check({tag, "_key_valid"}, key_valid, 0);
        check({tag, "_core_clear"}, core_clear, 0);
    endtask

    // One button press held 5 cycles then released for `gap` cycles. The strobe
    // must appear exactly 3 cycles after the press, for one cycle, if the model
    // says the keypad is open.
    task automatic press(input int idx, input int gap);
        int kv0;
        bit exp_kv;
        exp_kv = m_open;
        if (exp_kv) m_presses++;
        kv0 = kv_count;
        btn[idx] = 1'b1;
        tick(2);
        check("strobe_not_early", key_valid, 0);
        tick(1);
        check("key_valid", key_valid, exp_kv);
        check("key_code", key_code, exp_kv ? idx : 0);
        check("press_count", press_count, m_presses);
        tick(1);
        check("strobe_one_cycle", key_valid, 0);
        tick(1);
        btn[idx] = 1'b0;
        tick(gap);
        if (exp_kv && m_presses == CODE_LEN) m_open = 1'b0;
        check("strobe_total", kv_count - kv0, exp_kv);
    endtask

    // Full attempt with random buttons; returns 2 cycles after the last strobe.
    task automatic attempt();
        for (int i = 0; i < CODE_LEN; i++) begin
            press(int'($urandom_range(0, 2)), (i == CODE_LEN - 1) ? 0 : int'($urandom_range(3, 8)));
        end
    endtask

    // One-cycle verdict from the core, then the model's view of the outcome.
    task automatic give_verdict(input bit p, input bit f);
        core_pass = p;
        core_fail = f;
        tick(1);
        core_pass = 1'b0;
        core_fail = 1'b0;
        m_presses = 0;
        if (p && !f) begin
            m_fails = 0;
        end else begin
            m_fails++;
            m_open = (m_fails != MAX_FAILS);
        end
        check("verdict_unlocked", unlocked, p && !f);
        check("verdict_fail_count", fail_count, m_fails);
        check("verdict_press_count", press_count, 0);
        check("verdict_locked_out", locked_out, m_fails == MAX_FAILS);
    endtask

    initial begin
        int codes[5];
        int clr0;
        int kv0;
        int n;

        codes = '{2, 0, 1, 0, 2};
        reset = 1'b1;
        btn = 3'b000;
        core_pass = 1'b0;
        core_fail = 1'b0;
        tick(3);
        check_all_zero("reset");
        check("reset_key_code", key_code, 0);
        reset = 1'b0;
        tick(3);

        // Correct code and a pass: strobes 2,0,1,0,2 then a 20-cycle unlock.
        for (int i = 0; i < CODE_LEN; i++) press(codes[i], (i == CODE_LEN - 1) ? 0 : 4);
        give_verdict(1'b1, 1'b0);
        press(1, 2);
        n = 0;
        while (unlocked === 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check("unlock_ended", unlocked, 0);
        check("unlock_length", unl_len, UNLOCK_CYCLES);
        check("unlock_fail_count", fail_count, 0);
        m_open = 1'b1;

        // Three failed attempts lock the keypad; presses there are ignored.
        for (int a = 0; a < MAX_FAILS; a++) begin
            attempt();
            clr0 = clr_count;
            give_verdict(1'b0, 1'b1);
        end
        press(0, 2);
        n = 0;
        while (locked_out === 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check("lockout_ended", locked_out, 0);
        check("lockout_length", lo_len, LOCKOUT_CYCLES);
        check("lockout_fail_cleared", fail_count, 0);
        check("lockout_single_clear", clr_count - clr0, 1);
        check("lockout_clear_at_exit", clr_cyc, lo_fall);
        m_fails = 0;
        m_open = 1'b1;

        // Simultaneous rises and a rise under a held button are both rejected.
        kv0 = kv_count;
        btn = 3'b011;
        tick(5);
        btn = 3'b000;
        tick(5);
        btn = 3'b101;
        tick(5);
        btn = 3'b100;
        tick(5);
        btn = 3'b110;
        tick(5);
        btn = 3'b000;
        tick(5);
        check("rejected_no_strobe", kv_count - kv0, 0);
        check("rejected_press_count", press_count, 0);

        // Silent core after five presses: cleared after RESULT_TIMEOUT, one failure.
        clr0 = clr_count;
        attempt();
        n = 0;
        while (clr_count == clr0 && n < 40) begin
            tick(1);
            n++;
        end
        check("result_timeout_clear", clr_count - clr0, 1);
        check("result_timeout_delay", clr_cyc - kv_cyc, RESULT_TIMEOUT);
        m_fails++;
        m_presses = 0;
        m_open = 1'b1;
        check("result_timeout_fail_count", fail_count, m_fails);
        check("result_timeout_press_count", press_count, 0);

        // Two presses then silence: abort after KEY_TIMEOUT, failures untouched.
        press(int'($urandom_range(0, 2)), 4);
        clr0 = clr_count;
        press(int'($urandom_range(0, 2)), 0);
        n = 0;
        while (clr_count == clr0 && n < 60) begin
            tick(1);
            n++;
        end
        m_presses = 0;
        check("key_timeout_clear", clr_count - clr0, 1);
        check("key_timeout_delay", clr_cyc - kv_cyc, KEY_TIMEOUT);
        check("key_timeout_press_count", press_count, 0);
        check("key_timeout_fail_count", fail_count, m_fails);

        // Contradictory pass+fail is a failure (also shows IDLE was reached).
        attempt();
        give_verdict(1'b1, 1'b1);

        // Asynchronous reset in the middle of an unlock window.
        attempt();
        give_verdict(1'b1, 1'b0);
        tick(5);
        check("pre_reset_unlocked", unlocked, 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("reset_in_unlock");
        tick(2);
        reset = 1'b0;
        m_fails = 0;
        m_presses = 0;
        m_open = 1'b1;
        tick(2);
        press(int'($urandom_range(0, 2)), 3);
        tick(KEY_TIMEOUT + 4);
        m_presses = 0;
        check("post_reset_abort_press_count", press_count, 0);

        // Asynchronous reset in the middle of a lockout.
        for (int a = 0; a < MAX_FAILS; a++) begin
            attempt();
            give_verdict(1'b0, 1'b1);
        end
        tick(5);
        check("pre_reset_locked_out", locked_out, 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("reset_in_lockout");
        tick(2);
        reset = 1'b0;
        m_fails = 0;
        m_presses = 0;
        m_open = 1'b1;
        tick(2);
        press(int'($urandom_range(0, 2)), 3);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
